// File: rtl/game_control.sv
// Game sequencer: idle -> brick load -> aim -> run, with pause, level-clear and
// game-over handling. Tracks lives, level and the ball step period for the ball block.
module game_control #(
  parameter int unsigned PERIOD_BASE  = 500000,
  parameter int unsigned PERIOD_STEP  = 50000,
  parameter int unsigned PERIOD_MIN   = 150000,
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned MAX_LEVEL    = 5,
  parameter int unsigned LOAD_CYCLES  = 4,
  parameter int unsigned PAUSE_CYCLES = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        dead,
  input  logic        win,
  output logic [2:0]  state,
  output logic [2:0]  level,
  output logic [2:0]  angle,
  output logic [19:0] period,
  output logic [1:0]  lives,
  output logic        game_won
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_AIM   = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_CLEAR = 3'd5,
    S_OVER  = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  level_q, level_d;
  logic [2:0]  angle_q, angle_d;
  logic [19:0] period_q, period_d;
  logic [1:0]  lives_q, lives_d;
  logic        won_q, won_d;
  logic [24:0] cnt_q, cnt_d;

  // Bit order everywhere: {start, left, right}
  logic [2:0] sync1_q, sync2_q, prev_q;
  logic [2:0] press;
  logic       press_start, press_left, press_right;

  // Non-negative period arithmetic: the floor is chosen before subtracting.
  function automatic logic [19:0] calc_period(input logic [2:0] lvl);
    logic [31:0] dec;
    dec = 32'(lvl) * PERIOD_STEP;
    if (dec + PERIOD_MIN <= PERIOD_BASE) return 20'(PERIOD_BASE - dec);
    else return 20'(PERIOD_MIN);
  endfunction

  assign press       = sync2_q & ~prev_q;
  assign press_start = press[2];
  assign press_left  = press[1];
  assign press_right = press[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= {btn_start, btn_left, btn_right};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      level_q  <= '0;
      angle_q  <= 3'd3;
      period_q <= 20'(PERIOD_BASE);
      lives_q  <= 2'(LIVES_INIT);
      won_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      angle_q  <= angle_d;
      period_q <= period_d;
      lives_q  <= lives_d;
      won_q    <= won_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    angle_d  = angle_q;
    period_d = period_q;
    lives_d  = lives_q;
    won_d    = won_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (press_start) begin
          level_d = '0;
          lives_d = 2'(LIVES_INIT);
          won_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt_q == 25'(LOAD_CYCLES - 1)) begin
          period_d = calc_period(level_q);
          angle_d  = 3'd3;
          state_d  = S_AIM;
        end else begin
          cnt_d = cnt_q + 25'd1;
        end
      end
      S_AIM: begin
        if (press_start) begin
          state_d = S_RUN;
        end else if (press_left && !press_right && angle_q != 3'd0) begin
          angle_d = angle_q - 3'd1;
        end else if (press_right && !press_left && angle_q != 3'd5) begin
          angle_d = angle_q + 3'd1;
        end
      end
      S_RUN: begin
        // win outranks dead when both arrive together
        if (win) begin
          if (level_q == 3'(MAX_LEVEL)) begin
            won_d   = 1'b1;
            state_d = S_OVER;
          end else begin
            state_d = S_CLEAR;
          end
        end else if (dead) begin
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            state_d = S_AIM;
          end else begin
            lives_d = '0;
            state_d = S_OVER;
          end
        end else if (press_start) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (press_start) state_d = S_RUN;
      end
      S_CLEAR: begin
        if (cnt_q == 25'(PAUSE_CYCLES - 1)) begin
          level_d = level_q + 3'd1;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + 25'd1;
        end
      end
      S_OVER: begin
        if (press_start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  assign state    = state_q;
  assign level    = level_q;
  assign angle    = angle_q;
  assign period   = period_q;
  assign lives    = lives_q;
  assign game_won = won_q;

endmodule

// File: doc/game_control.md
Name: game_control

Overview:
- Top-level game sequencer. Produces `state`, `level`, `angle` and `period` for the ball/brick logic block, and consumes that block's `dead` and `win` flags.
- Sequences the game: idle → brick load → aim → run, with pause, level-clear and game-over handling.
- Tracks lives and level progression.
- Sits between the debounced button inputs and the ball block.

Parameters:
- PERIOD_BASE, 500000, level-0 ball step period in clocks.
- PERIOD_STEP, 50000, period reduction per level.
- PERIOD_MIN, 150000, floor on period.
- LIVES_INIT, 3, lives at game start (1..3).
- MAX_LEVEL, 5, last level index.
- LOAD_CYCLES, 4, clocks spent in LOAD.
- PAUSE_CYCLES, 25000000, clocks spent in CLEAR before the next level loads.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- btn_start  in  1  debounced level signal; launch / pause / start
- btn_left  in  1  debounced level signal; angle decrement
- btn_right  in  1  debounced level signal; angle increment
- dead  in  1  ball lost, from ball block
- win  in  1  all bricks cleared, from ball block
- state  out  3  0 IDLE, 1 LOAD, 2 AIM, 3 RUN, 4 PAUSE, 5 CLEAR, 6 OVER
- level  out  3  current level 0..MAX_LEVEL
- angle  out  3  launch angle 0..5
- period  out  20  ball step period
- lives  out  2  remaining lives
- game_won  out  1  set when the last level is cleared

Behaviour:
- Reset (rst low, async):
  - state=0, level=0, angle=3, period=PERIOD_BASE, lives=LIVES_INIT, game_won=0.
  - Edge-detector history and counter cleared.
- Button inputs:
  - Each button passes through a 2-flop synchronizer.
  - A press is a rising edge of the synchronized signal, detected one clock after sync. This gives 3 clocks from pin edge to action.
  - A held button produces exactly one press.
- IDLE:
  - On start press: level←0, lives←LIVES_INIT, game_won←0, counter←0, go to LOAD.
- LOAD:
  - Counter increments each clock.
  - On reaching LOAD_CYCLES-1: period←max(PERIOD_BASE − level·PERIOD_STEP, PERIOD_MIN); angle←3; go to AIM.
  - Period is computed with non-negative arithmetic, so there is no wrap when level·STEP > BASE.
  - Buttons are ignored.
- AIM:
  - Left press: angle−1, saturating at 0.
  - Right press: angle+1, saturating at 5.
  - Left and right in the same clock: no change.
  - Start press: go to RUN; angle is frozen.
- RUN, priority high to low:
  1. win=1:
     - If level==MAX_LEVEL: game_won←1, go to OVER.
     - Otherwise: counter←0, go to CLEAR.
  2. dead=1:
     - If lives>1: lives−1, go to AIM. Bricks are preserved because LOAD is skipped.
     - Otherwise: lives←0, go to OVER.
  3. Start press: go to PAUSE.
  - win and dead asserted in the same clock are treated as win.
- PAUSE:
  - dead, win, left and right are ignored.
  - Start press returns to RUN.
- CLEAR:
  - Counter increments.
  - On reaching PAUSE_CYCLES-1: level+1, counter←0, go to LOAD.
- OVER:
  - Start press goes to IDLE; lives and level hold until that point.
- dead and win are only sampled in RUN. Stale values in other states are ignored, because the ball block clears them in AIM.
- Every transition takes exactly one clock. state is registered, with no combinational path from inputs.
- Counter is 25 bits. It is cleared on every state entry and never wraps within a state.
- Reset asserted mid-game returns everything to the reset values immediately.

Test Plan (LOAD_CYCLES=2, PAUSE_CYCLES=8, LIVES_INIT=3, MAX_LEVEL=5):
- Reset → start press:
  - state 0 → 1, held 2 clocks, then 2.
  - period=500000, angle=3, lives=3.
- In AIM, right ×3 then left ×7:
  - angle goes 4, 5, 5, then 4…0 and stays 0.
  - Start press → state=3.
- In RUN, pulse dead three times, returning to RUN from AIM each time:
  - lives 2 → AIM, lives 1 → AIM, then OVER with lives=0.
  - Start press → IDLE.
- In RUN at level 0, assert win:
  - state 5 for 8 clocks, then LOAD with level=1, then AIM with period=450000.
- Force level 4, then win:
  - level 5, period=max(250000, 150000)=250000.
  - win at level 5 → OVER with game_won=1.
- Edge cases:
  - win and dead in the same clock → CLEAR, lives unchanged.
  - Start held high for 20 clocks in RUN → PAUSE only, no toggle back.
  - rst low mid-CLEAR → all outputs return to reset values asynchronously.
